// File: rtl/inst_decode_pkg.sv
// Shared field map, decoded-record type and opcode classes
// for the instruction decode stage.
package inst_decode_pkg;

   localparam int INST_W = 24;
   localparam int MAX_W  = 32;

   localparam int OPC_HI = 23;
   localparam int OPC_LO = 20;
   localparam int APA_HI = 19;
   localparam int APA_LO = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RA_HI  = 8;
   localparam int RA_LO  = 6;
   localparam int RB_HI  = 5;
   localparam int RB_LO  = 3;
   localparam int FN_HI  = 2;
   localparam int FN_LO  = 0;
   localparam int APD_HI = 11;
   localparam int APD_LO = 4;
   localparam int DEV_HI = 3;
   localparam int DEV_LO = 0;
   localparam int ADR_HI = 6;
   localparam int ADR_LO = 0;

   typedef enum logic [1:0] {
      CLS_ALU    = 2'd0,
      CLS_APB_WR = 2'd1,
      CLS_APB_RD = 2'd2
   } op_class_e;

   // imm/addr are held at the widest legal DATA_W; the stage
   // presents only the low DATA_W bits.
   typedef struct packed {
      logic [3:0]       opcode;
      logic [2:0]       rd_addr;
      logic [2:0]       ra_addr;
      logic [2:0]       rb_addr;
      logic [2:0]       func;
      logic [MAX_W-1:0] imm;
      logic [MAX_W-1:0] addr;
      logic [7:0]       apb_addr;
      logic [7:0]       apb_data;
      logic [3:0]       apb_device;
      op_class_e        cls;
      logic             illegal;
   } dec_rec_t;

endpackage

// File: rtl/inst_decode_stage_skid.sv
// Two-entry valid/ready skid buffer for decoded records.
// in_ready depends only on the state register.
module skid_buffer_2
   import inst_decode_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     flush,
   input  logic     in_valid,
   output logic     in_ready,
   input  dec_rec_t in_data,
   output logic     out_valid,
   input  logic     out_ready,
   output dec_rec_t out_data
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0] state_q, state_d;
   dec_rec_t   main_q, main_d;
   dec_rec_t   skid_q, skid_d;
   logic       acc;
   logic       hs;

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign acc       = in_valid && in_ready;
   assign hs        = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (acc) begin
                  state_d = LOAD;
                  main_d  = in_data;
               end
            end
            LOAD: begin
               if (acc && !hs) begin
                  state_d = FULL;
                  skid_d  = in_data;
               end else if (acc && hs) begin
                  main_d = in_data;
               end else if (hs) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (hs) begin
                  state_d = LOAD;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/inst_decode_stage.sv
// Registered decode stage: field split, sign extension,
// classification and handshake counter around a skid buffer.
module inst_decode_stage
   import inst_decode_pkg::*;
#(
   parameter int          DATA_W    = 8,
   parameter logic [3:0]  APB_WR_OP = 4'hE,
   parameter logic [3:0]  APB_RD_OP = 4'hF,
   parameter logic [15:0] LEGAL_OPS = 16'hFFFF,
   parameter int          CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [23:0]       inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        opcode,
   output logic [2:0]        rd_addr,
   output logic [2:0]        ra_addr,
   output logic [2:0]        rb_addr,
   output logic [2:0]        func,
   output logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] addr,
   output logic [7:0]        apb_addr,
   output logic [7:0]        apb_data,
   output logic [3:0]        apb_device,
   output logic              is_apb_wr,
   output logic              is_apb_rd,
   output logic              illegal,
   output logic [CNT_W-1:0]  dec_count
);

   function automatic dec_rec_t decode(input logic [INST_W-1:0] w);
      dec_rec_t   r;
      logic [5:0] i6;
      logic [3:0] op;
      op           = w[OPC_HI:OPC_LO];
      i6           = {w[RD_HI:RD_LO], w[FN_HI:FN_LO]};
      r.opcode     = op;
      r.rd_addr    = w[RD_HI:RD_LO];
      r.ra_addr    = w[RA_HI:RA_LO];
      r.rb_addr    = w[RB_HI:RB_LO];
      r.func       = w[FN_HI:FN_LO];
      r.imm        = {{(MAX_W-6){i6[5]}}, i6};
      r.addr       = {{(MAX_W-7){w[ADR_HI]}}, w[ADR_HI:ADR_LO]};
      r.apb_addr   = w[APA_HI:APA_LO];
      r.apb_data   = w[APD_HI:APD_LO];
      r.apb_device = w[DEV_HI:DEV_LO];
      r.illegal    = !LEGAL_OPS[op];
      unique case (1'b1)
         (op == APB_WR_OP): r.cls = CLS_APB_WR;
         (op == APB_RD_OP): r.cls = CLS_APB_RD;
         default:           r.cls = CLS_ALU;
      endcase
      return r;
   endfunction

   dec_rec_t           dec_rec;
   dec_rec_t           out_rec;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               unused_rec;

   assign dec_rec = decode(inst);

   skid_buffer_2 u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (dec_rec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_rec)
   );

   assign opcode     = out_rec.opcode;
   assign rd_addr    = out_rec.rd_addr;
   assign ra_addr    = out_rec.ra_addr;
   assign rb_addr    = out_rec.rb_addr;
   assign func       = out_rec.func;
   assign imm        = out_rec.imm[DATA_W-1:0];
   assign addr       = out_rec.addr[DATA_W-1:0];
   assign apb_addr   = out_rec.apb_addr;
   assign apb_data   = out_rec.apb_data;
   assign apb_device = out_rec.apb_device;
   assign is_apb_wr  = (out_rec.cls == CLS_APB_WR);
   assign is_apb_rd  = (out_rec.cls == CLS_APB_RD);
   assign illegal    = out_rec.illegal;
   assign unused_rec = ^{out_rec.imm, out_rec.addr};

   // Counts delivered records even in a flush cycle.
   assign cnt_d = (out_valid && out_ready) ? cnt_q + CNT_W'(1)
                                           : cnt_q;
   assign dec_count = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
